// File: rtl/uart_tx_sequencer.sv
// Byte-stream to AXI write sequencer for a UART slave: issues the setup write after
// reset, then forwards each accepted byte as a single-beat write to the TX data register.
package uart_tx_sequencer_pkg;

    typedef struct packed {
        logic [3:0]  aw_id;
        logic [31:0] aw_addr;
        logic [7:0]  aw_len;
        logic [2:0]  aw_size;
        logic [1:0]  aw_burst;
        logic [2:0]  aw_prot;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [3:0]  ar_id;
        logic [31:0] ar_addr;
        logic [7:0]  ar_len;
        logic [2:0]  ar_size;
        logic [1:0]  ar_burst;
        logic [2:0]  ar_prot;
        logic        ar_valid;
        logic        r_ready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
        logic        ar_ready;
        logic [3:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
    } s_axi_miso_t;

endpackage

module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter logic [30:0] SETUP_VAL   = 31'd25,
    parameter logic [31:0] SETUP_ADDR  = 32'h0,
    parameter logic [31:0] TXDATA_ADDR = 32'hC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid_i,
    input  logic [7:0]  s_data_i,
    output logic        s_ready_o,
    output s_axi_mosi_t axi_mosi,
    input  s_axi_miso_t axi_miso,
    output logic        cfg_done_o,
    output logic        busy_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [2:0] {
        CFG_REQ = 3'd0,
        CFG_RSP = 3'd1,
        IDLE    = 3'd2,
        WR_REQ  = 3'd3,
        WR_RSP  = 3'd4
    } state_t;

    state_t     state_r, state_s;
    logic       aw_valid_r, w_valid_r, aw_done_r, w_done_r;
    logic       aw_valid_s, w_valid_s, aw_done_s, w_done_s;
    logic       b_ready_r, s_ready_r, busy_r, cfg_done_r;
    logic [7:0] data_r, err_cnt_r;
    logic       aw_hs_s, w_hs_s, b_hs_s, b_err_s;
    logic       unused_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'hFF) begin
            res = v;
        end else begin
            res = v + 8'd1;
        end
        return res;
    endfunction

    assign aw_hs_s  = aw_valid_r & axi_miso.aw_ready;
    assign w_hs_s   = w_valid_r & axi_miso.w_ready;
    assign b_hs_s   = b_ready_r & axi_miso.b_valid;
    assign b_err_s  = b_hs_s & (axi_miso.b_resp != 2'b00);
    assign unused_s = ^{axi_miso.b_id, axi_miso.ar_ready, axi_miso.r_id, axi_miso.r_data,
                        axi_miso.r_resp, axi_miso.r_last, axi_miso.r_valid};

    // Next-state logic; valid=0 with done=0 in a request state means "not yet launched"
    always_comb begin
        state_s    = state_r;
        aw_valid_s = aw_valid_r;
        w_valid_s  = w_valid_r;
        aw_done_s  = aw_done_r;
        w_done_s   = w_done_r;
        case (state_r)
            CFG_REQ, WR_REQ: begin
                if (aw_valid_r) begin
                    aw_valid_s = ~axi_miso.aw_ready;
                end else begin
                    aw_valid_s = ~aw_done_r;
                end
                if (w_valid_r) begin
                    w_valid_s = ~axi_miso.w_ready;
                end else begin
                    w_valid_s = ~w_done_r;
                end
                aw_done_s = aw_done_r | aw_hs_s;
                w_done_s  = w_done_r | w_hs_s;
                if (aw_done_s && w_done_s) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    if (state_r == CFG_REQ) begin
                        state_s = CFG_RSP;
                    end else begin
                        state_s = WR_RSP;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            CFG_RSP, WR_RSP: begin
                if (b_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            IDLE: begin
                if (s_valid_i) begin
                    state_s    = WR_REQ;
                    aw_valid_s = 1'b1;
                    w_valid_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s    = CFG_REQ;
                aw_valid_s = 1'b0;
                w_valid_s  = 1'b0;
                aw_done_s  = 1'b0;
                w_done_s   = 1'b0;
            end
        endcase
    end

    // State, handshake tracking and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= CFG_REQ;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            b_ready_r  <= 1'b0;
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b1;
            cfg_done_r <= 1'b0;
            err_cnt_r  <= 8'h00;
            data_r     <= 8'h00;
        end else begin
            state_r    <= state_s;
            aw_valid_r <= aw_valid_s;
            w_valid_r  <= w_valid_s;
            aw_done_r  <= aw_done_s;
            w_done_r   <= w_done_s;
            b_ready_r  <= (state_s == CFG_RSP) || (state_s == WR_RSP);
            s_ready_r  <= (state_s == IDLE);
            busy_r     <= (state_s != IDLE);
            if (b_hs_s && (state_r == CFG_RSP)) begin
                cfg_done_r <= 1'b1;
            end
            if (b_err_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
            if (s_valid_i && s_ready_r) begin
                data_r <= s_data_i;
            end
        end
    end

    // AXI request fields; everything not driven here stays zero
    always_comb begin
        axi_mosi          = '0;
        axi_mosi.aw_addr  = (state_r == CFG_REQ) ? SETUP_ADDR : TXDATA_ADDR;
        axi_mosi.aw_size  = 3'b010;
        axi_mosi.aw_burst = 2'b01;
        axi_mosi.aw_valid = aw_valid_r;
        axi_mosi.w_data   = (state_r == CFG_REQ) ? {1'b0, SETUP_VAL} : {24'h000000, data_r};
        axi_mosi.w_strb   = 4'hF;
        axi_mosi.w_last   = w_valid_r;
        axi_mosi.w_valid  = w_valid_r;
        axi_mosi.b_ready  = b_ready_r;
        axi_mosi.r_ready  = 1'b1;
    end

    assign s_ready_o  = s_ready_r;
    assign cfg_done_o = cfg_done_r;
    assign busy_o     = busy_r;
    assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: directed byte stimulus against a configurable
// AXI slave model; expected writes are queued at issue time and popped by a write monitor.
module tb_uart_tx_sequencer;
    import uart_tx_sequencer_pkg::*;

    localparam logic [31:0] SETUP_ADDR_C  = 32'h0;
    localparam logic [31:0] TXDATA_ADDR_C = 32'hC;
    localparam logic [31:0] SETUP_WORD_C  = 32'h00000019;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_ready_o, cfg_done_o, busy_o;
    logic [7:0]  err_cnt_o;
    s_axi_mosi_t axi_mosi;
    s_axi_miso_t axi_miso;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    int       aw_lat = 1, w_lat = 1, b_lat = 0;
    logic [1:0] resp_cfg = 2'b00;
    logic     spur = 1'b0;
    logic     sl_aw_ready, sl_w_ready, sl_b_valid;
    logic [1:0] sl_b_resp;
    int       n_writes = 0, cnt_aw = 0, cnt_w = 0, cnt_b = 0;

    uart_tx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid_i  (s_valid_i),
        .s_data_i   (s_data_i),
        .s_ready_o  (s_ready_o),
        .axi_mosi   (axi_mosi),
        .axi_miso   (axi_miso),
        .cfg_done_o (cfg_done_o),
        .busy_o     (busy_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        axi_miso          = '0;
        axi_miso.aw_ready = sl_aw_ready;
        axi_miso.w_ready  = sl_w_ready;
        axi_miso.b_valid  = sl_b_valid | spur;
        axi_miso.b_resp   = spur ? 2'b10 : sl_b_resp;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: ready after a programmable number of valid cycles, B after both beats
    initial begin
        int aw_cnt, w_cnt, b_cnt;
        bit got_aw, got_w;
        sl_aw_ready = 1'b0; sl_w_ready = 1'b0; sl_b_valid = 1'b0; sl_b_resp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; got_aw = 1'b0; got_w = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sl_aw_ready = 1'b0; sl_w_ready = 1'b0; sl_b_valid = 1'b0; sl_b_resp = 2'b00;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; got_aw = 1'b0; got_w = 1'b0;
            end else begin
                if (sl_b_valid) begin
                    sl_b_valid = 1'b0;
                end else if (got_aw && got_w) begin
                    if (b_cnt >= b_lat) begin
                        sl_b_valid = 1'b1; sl_b_resp = resp_cfg;
                        got_aw = 1'b0; got_w = 1'b0; b_cnt = 0;
                    end else begin
                        b_cnt++;
                    end
                end
                if (axi_mosi.aw_valid && !got_aw) begin
                    if (aw_cnt >= aw_lat - 1) begin
                        sl_aw_ready = 1'b1; got_aw = 1'b1; aw_cnt = 0;
                    end else begin
                        sl_aw_ready = 1'b0; aw_cnt++;
                    end
                end else begin
                    sl_aw_ready = 1'b0;
                end
                if (axi_mosi.w_valid && !got_w) begin
                    if (w_cnt >= w_lat - 1) begin
                        sl_w_ready = 1'b1; got_w = 1'b1; w_cnt = 0;
                    end else begin
                        sl_w_ready = 1'b0; w_cnt++;
                    end
                end else begin
                    sl_w_ready = 1'b0;
                end
            end
        end
    end

    // Write monitor: assembles AW+W handshakes and compares against the expected queue
    initial begin
        bit m_aw, m_w;
        logic [31:0] m_addr, m_data;
        logic [63:0] e;
        m_aw = 1'b0; m_w = 1'b0; m_addr = '0; m_data = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_aw = 1'b0; m_w = 1'b0;
            end else begin
                if (axi_mosi.aw_valid) cnt_aw++;
                if (axi_mosi.w_valid) cnt_w++;
                if (axi_mosi.b_ready) cnt_b++;
                if (axi_mosi.aw_valid && axi_miso.aw_ready) begin
                    m_aw = 1'b1; m_addr = axi_mosi.aw_addr;
                end
                if (axi_mosi.w_valid && axi_miso.w_ready) begin
                    m_w = 1'b1; m_data = axi_mosi.w_data;
                    check("w_last", 32'(axi_mosi.w_last), 32'd1);
                end
                if (m_aw && m_w) begin
                    m_aw = 1'b0; m_w = 1'b0; n_writes++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", m_addr, m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", m_addr, e[63:32]);
                        check("wr_data", m_data, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit && !ok; n++) begin
            if (s_ready_o) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_ready: got timeout after %0d cycles, expected s_ready_o=1", limit);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep, output time acc);
        bit ok;
        ok = 1'b0; acc = 0;
        s_valid_i = 1'b1; s_data_i = b;
        exp_q.push_back({TXDATA_ADDR_C, 24'h000000, b});
        for (int n = 0; n < 100 && !ok; n++) begin
            if (s_ready_o) begin
                @(posedge clk);
                acc = $time; ok = 1'b1;
                @(negedge clk);
                if (!keep) s_valid_i = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            checks++; errors++; s_valid_i = 1'b0;
            $display("FAIL send_byte: got no accept for 0x%0h, expected accept", b);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
        check({tag, "_cfg_done"}, 32'(cfg_done_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
        check({tag, "_awvalid"}, 32'(axi_mosi.aw_valid), 32'd0);
        check({tag, "_wvalid"}, 32'(axi_mosi.w_valid), 32'd0);
        check({tag, "_bready"}, 32'(axi_mosi.b_ready), 32'd0);
    endtask

    initial begin
        time t0, t1;
        int  w0;
        rst = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        check("aw_size", 32'(axi_mosi.aw_size), 32'd2);
        check("aw_burst", 32'(axi_mosi.aw_burst), 32'd1);
        check("aw_len", 32'(axi_mosi.aw_len), 32'd0);
        check("w_strb", 32'(axi_mosi.w_strb), 32'hF);
        check("r_ready", 32'(axi_mosi.r_ready), 32'd1);
        check("ar_valid", 32'(axi_mosi.ar_valid), 32'd0);

        // setup write after reset release
        exp_q.push_back({SETUP_ADDR_C, SETUP_WORD_C});
        rst = 1'b1;
        @(negedge clk);
        check("first_awvalid", 32'(axi_mosi.aw_valid), 32'd1);
        check("first_wvalid", 32'(axi_mosi.w_valid), 32'd1);
        wait_ready(20);
        check("cfg_done", 32'(cfg_done_o), 32'd1);
        check("cfg_s_ready", 32'(s_ready_o), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("cfg_writes", 32'(n_writes), 32'd1);

        // back-to-back bytes with an ideal slave
        w0 = n_writes;
        send_byte(8'h41, 1'b1, t0);
        send_byte(8'h42, 1'b0, t1);
        check("byte_latency", 32'((t1 - t0) / 10), 32'd3);
        wait_ready(20);
        check("b2b_writes", 32'(n_writes - w0), 32'd2);

        // slow AW, immediate W; data changed while in flight
        aw_lat = 4; cnt_aw = 0; cnt_w = 0; cnt_b = 0; w0 = n_writes;
        send_byte(8'h5A, 1'b0, t0);
        s_data_i = 8'hEE;
        wait_ready(50);
        check("slow_aw_cycles", 32'(cnt_aw), 32'd4);
        check("slow_w_cycles", 32'(cnt_w), 32'd1);
        check("slow_b_wait", 32'(cnt_b), 32'd1);
        check("slow_writes", 32'(n_writes - w0), 32'd1);
        aw_lat = 1;

        // stray bvalid while idle must be ignored
        cnt_b = 0; spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        check("spur_err_cnt", 32'(err_cnt_o), 32'd0);
        check("spur_s_ready", 32'(s_ready_o), 32'd1);
        check("spur_bready", 32'(cnt_b), 32'd0);

        // SLVERR responses saturate the error counter
        resp_cfg = 2'b10;
        for (int i = 1; i <= 300; i++) begin
            send_byte(i[7:0], 1'b0, t0);
            wait_ready(20);
            if (i == 10) check("err_cnt_10", 32'(err_cnt_o), 32'd10);
            if (i == 255) check("err_cnt_255", 32'(err_cnt_o), 32'hFF);
        end
        check("err_cnt_300", 32'(err_cnt_o), 32'hFF);
        check("err_idle", 32'(s_ready_o), 32'd1);
        resp_cfg = 2'b00;

        // reset while waiting for B
        b_lat = 6; w0 = n_writes;
        send_byte(8'h77, 1'b0, t0);
        for (int n = 0; n < 20 && !axi_mosi.b_ready; n++) @(negedge clk);
        check("in_wr_rsp", 32'(axi_mosi.b_ready), 32'd1);
        rst = 1'b0; b_lat = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("mid");
        exp_q.push_back({SETUP_ADDR_C, SETUP_WORD_C});
        rst = 1'b1;
        @(negedge clk);
        check("reissue_awvalid", 32'(axi_mosi.aw_valid), 32'd1);
        wait_ready(20);
        check("recfg_done", 32'(cfg_done_o), 32'd1);
        repeat (10) @(negedge clk);
        check("reset_writes", 32'(n_writes - w0), 32'd2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameters SHALL be:
- SETUP_VAL, 31'd25, baud/format word written to the UART setup register after reset
- SETUP_ADDR, 32'h0, setup register address
- TXDATA_ADDR, 32'hC, TX data register address
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-low reset; 0 = reset
- s_valid_i  in  1  byte stream valid
- s_data_i  in  8  byte stream data
- s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o
- axi_mosi  out  s_axi_mosi_t  AXI master request to the UART slave port
- axi_miso  in  s_axi_miso_t  AXI response from the UART slave port
- cfg_done_o  out  1  setup write completed
- busy_o  out  1  write transaction in flight
- err_cnt_o  out  8  count of non-OKAY write responses, saturating
REQ-003 Static AXI fields SHALL be constant:
- awid=0, awlen=0, awsize=3'b010, awburst=INCR, awprot=0, wlast=wvalid
- arvalid=0, rready=1; all other AR fields 0
- wstrb=4'hF

Function
REQ-004 FSM states SHALL be CFG_REQ, CFG_RSP, IDLE, WR_REQ, WR_RSP.
REQ-005 CFG_REQ: awvalid=wvalid=1, awaddr=SETUP_ADDR, wdata={1'b0,SETUP_VAL}; go to CFG_RSP once both AW and W have handshaken.
REQ-006 AW and W SHALL be issued in the same cycle and dropped independently:
- awvalid clears the cycle after awvalid&&awready
- wvalid clears the cycle after wvalid&&wready
- either order, or both in the same cycle, is legal; state advances only when both are done
REQ-007 CFG_RSP: bready=1; on bvalid go to IDLE and set cfg_done_o=1 (held until reset).
REQ-008 IDLE: s_ready_o=1 only in IDLE.
- on s_valid_i: latch s_data_i into an 8-bit holding register, go to WR_REQ
- s_ready_o SHALL be 0 in every other state
REQ-009 WR_REQ: same as REQ-005/006 but awaddr=TXDATA_ADDR, wdata={24'b0,held byte}; go to WR_RSP when both handshakes are done.
REQ-010 WR_RSP: bready=1; on bvalid go to IDLE.
REQ-011 bready SHALL be 0 outside CFG_RSP and WR_RSP.
REQ-012 Error counting:
- any bvalid&&bready with bresp!=2'b00 increments err_cnt_o
- saturates at 8'hFF
- the FSM proceeds normally on error (no retry)
REQ-013 busy_o SHALL be 1 in CFG_REQ, CFG_RSP, WR_REQ, WR_RSP and 0 in IDLE.
REQ-014 Minimum IDLE-to-IDLE latency SHALL be 3 cycles per byte: 1 cycle IDLE accept, 1 cycle WR_REQ with same-cycle AW/W ready, 1 cycle WR_RSP with immediate bvalid.
REQ-015 The held byte SHALL NOT change while a write is in flight; s_data_i changes outside IDLE are ignored.
REQ-016 bvalid arriving in any state other than CFG_RSP/WR_RSP SHALL be ignored (bready=0) and SHALL NOT affect err_cnt_o.

Reset
REQ-017 While rst=0 at posedge:
- state=CFG_REQ
- awvalid=wvalid=bready=0
- s_ready_o=0, cfg_done_o=0, busy_o=1, err_cnt_o=0, holding register=0
REQ-018 The first cycle after rst rises SHALL present awvalid=wvalid=1 for the setup write.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no completion tracking, and the setup write SHALL be reissued after release; the UART slave is reset with the same rst.

Verification
REQ-020 Release reset, slave with awready=wready=1 and bvalid one cycle later -> one write awaddr=0x0 wdata=0x00000019, then cfg_done_o=1, s_ready_o=1.
REQ-021 After config, s_data_i=8'h41 held valid with an ideal slave -> write awaddr=0xC wdata=0x00000041; next byte accepted 3 cycles after the first.
REQ-022 awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B wait, exactly one write.
REQ-023 bresp=2'b10 on 300 consecutive writes -> err_cnt_o reaches 8'hFF and stays; FSM keeps returning to IDLE.
REQ-024 rst=0 asserted during WR_RSP, then released -> outputs at reset values, a new setup write, and the pending byte never rewritten.
